simon_playback_ctrl: RTL and testbench
======================================

// Module: simon_playback_ctrl
// PURPOSE
//  Sequences playback of the stored Simon pattern memory onto the pattern LEDs.
//  - On start, walks entries first_addr..last_addr (inclusive, wrapping).
//  - Each entry is shown for ON_CYCLES, followed by a blanked gap of GAP_CYCLES.
//  - Issued by the Simon control FSM in its playback mode; replaces per-cycle
//    curr_ld stepping with timed, handshaked playback.
// PARAMETERS
//  ADDR_W      6  pattern memory address width (depth 2**ADDR_W)
//  LED_W       4  pattern/LED width
//  ON_CYCLES   4  cycles each entry is lit; legal range >=1
//  GAP_CYCLES  2  blank cycles after each entry; 0 skips the GAP state
//  CNT_W       8  timer width; must hold max(ON_CYCLES,GAP_CYCLES)-1
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  start       in   1       1-cycle request; sampled only in IDLE
//  abort       in   1       cancel playback; honoured in any state
//  first_addr  in   ADDR_W  first entry; latched on accepted start
//  last_addr   in   ADDR_W  last entry; latched on accepted start
//  rd_addr     out  ADDR_W  memory read address (registered)
//  rd_data     in   LED_W   memory data, combinational read of rd_addr
//  leds        out  LED_W   registered LED drive
//  busy        out  1       high in every state except IDLE
//  done        out  1       1-cycle pulse on normal completion
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rd_addr=0, leds=0, busy=0, done=0;
//   latched pointers and timer cleared.
//  FSM states: IDLE, LOAD, SHOW, GAP, DONE.
//  - IDLE: start&!abort -> latch first/last, curr=first, rd_addr=first -> LOAD.
//  - LOAD (1 cycle): leds<=rd_data at clock edge; timer=ON_CYCLES-1 -> SHOW.
//  - SHOW: leds hold; timer decrements; at timer==0 -> leds<=0.
//    Next state is GAP (timer=GAP_CYCLES-1) if GAP_CYCLES>0, else the step-end decision.
//  - GAP: leds=0; at timer==0 -> step-end decision.
//  - Step end:
//    - curr==last -> DONE.
//    - else curr=curr+1 mod 2**ADDR_W, rd_addr=curr+1 -> LOAD.
//  - DONE (1 cycle): done=1, busy=1 -> IDLE.
//  Timing:
//  - start sampled at cycle 0; LOAD at cycle 1; leds valid cycles 2..1+ON_CYCLES.
//  - Step period P = 1+ON_CYCLES+GAP_CYCLES.
//  - N entries -> done high in cycle 1+N*P; busy high cycles 1..1+N*P.
//  Boundaries:
//  - first==last: exactly one entry shown.
//  - last<first: wraps through 2**ADDR_W-1 to 0 (N = last-first+2**ADDR_W+1).
//  - first==last+1 mod depth: full memory, N=2**ADDR_W.
//  - start while busy: ignored; latched pointers do not change.
//  - abort in non-IDLE: next state IDLE; leds=0, busy=0, no done pulse.
//  - abort&start in IDLE: abort wins; no playback.
//  - abort in DONE: done still asserted that cycle (already registered).
//  - first_addr/last_addr changing mid-playback: no effect.
//  - rst mid-playback: immediate reset values; no done.
// STRUCTURE
//  simon_pkg:
//  - playback state enum (IDLE, LOAD, SHOW, GAP, DONE) as localparams.
//  - LED_W default and blank pattern constant.
//  Sub-module simon_step_timer:
//  - CNT_W down-counter with load/value inputs and an expire (==0) output.
//  - Used for both the SHOW and GAP intervals.
// TESTING (defaults, P=7; mem[i]=i[3:0]^4'hA)
//  1 Single entry: first=last=3, start@0.
//    -> rd_addr=3; leds=4'h9 cycles 2-5; leds=0 cycles 6-7; done@8 only; busy 1-8.
//  2 Three entries: first=5, last=7.
//    -> leds show F,C,D (pattern i^A) starting at cycles 2, 9, 16; done@22.
//  3 Wrap: first=62, last=1 -> rd_addr 62,63,0,1; done@29; no glitch on leds at wrap.
//  4 Abort in SHOW of second entry (cycle 10) -> IDLE at 11; leds=0, busy=0; done never pulses.
//  5 start pulsed again at cycles 3 and 8 with new pointers -> ignored; playback unchanged.
//    abort&start in IDLE -> busy stays 0.
//  6 GAP_CYCLES=0 build, first=0, last=1 -> SHOW directly to LOAD; done@11.
//    Also: rst low at cycle 4 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for Simon pattern playback.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SHOW = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } pb_state_t;

  localparam int LED_W_DEF = 4;
  localparam logic [LED_W_DEF-1:0] LED_BLANK = '0;

endpackage

// File: rtl/simon_step_timer.sv
// Loadable down-counter that parks at zero; expire flags the last cycle of an interval.
module simon_step_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/simon_playback_ctrl.sv
// Timed playback of pattern memory entries first..last (wrapping) onto the LEDs,
// each lit for ON_CYCLES then blanked for GAP_CYCLES.
module simon_playback_ctrl
  import simon_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int LED_W      = LED_W_DEF,
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [LED_W-1:0]  rd_data,
  output logic [LED_W-1:0]  leds,
  output logic              busy,
  output logic              done
);

  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] ON_INIT  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_INIT = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

  pb_state_t         state;
  logic [ADDR_W-1:0] curr, last_q;
  logic              tmr_load, tmr_exp, step_end;
  logic [CNT_W-1:0]  tmr_val;

  // Timer is armed on entry to SHOW (from LOAD) and on entry to GAP.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = ON_INIT;
    if (state == ST_LOAD) begin
      tmr_load = 1'b1;
    end else if (state == ST_SHOW && tmr_exp && HAS_GAP) begin
      tmr_load = 1'b1;
      tmr_val  = GAP_INIT;
    end
  end

  assign step_end = tmr_exp && ((state == ST_GAP) || (state == ST_SHOW && !HAS_GAP));

  simon_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_val),
    .expire (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      curr    <= '0;
      last_q  <= '0;
      rd_addr <= '0;
      leds    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state <= ST_IDLE;
      leds  <= LED_W'(LED_BLANK);
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start && !abort) begin
          curr    <= first_addr;
          last_q  <= last_addr;
          rd_addr <= first_addr;
          busy    <= 1'b1;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          leds  <= rd_data;
          state <= ST_SHOW;
        end
        ST_SHOW: if (tmr_exp) begin
          leds <= LED_W'(LED_BLANK);
          if (HAS_GAP) state <= ST_GAP;
        end
        ST_GAP: ;
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Later assignments override the SHOW/GAP defaults above.
      if (step_end) begin
        if (curr == last_q) begin
          done  <= 1'b1;
          state <= ST_DONE;
        end else begin
          curr    <= curr + 1'b1;
          rd_addr <= curr + 1'b1;
          state   <= ST_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Randomized scoreboard bench: two builds (GAP=2 and GAP=0) share stimulus; a cycle-level
// reference trace derived from the timing rules is queued per playback and popped by monitors.
module tb_simon_playback_ctrl;

  localparam int ON    = 4;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [5:0] addr;
  } exp_t;

  logic       clk, rst, start, abort;
  logic [5:0] first_addr, last_addr;
  logic [5:0] rd_addr_a, rd_addr_b;
  logic [3:0] rd_data_a, rd_data_b, leds_a, leds_b;
  logic       busy_a, busy_b, done_a, done_b;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  exp_t qa[$], qb[$], tmp[$];
  exp_t ea, eb;

  assign rd_data_a = rd_addr_a[3:0] ^ 4'hA;
  assign rd_data_b = rd_addr_b[3:0] ^ 4'hA;

  simon_playback_ctrl #(.GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .leds(leds_a), .busy(busy_a), .done(done_a));

  simon_playback_ctrl #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .leds(leds_b), .busy(busy_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int a);
    return 4'((a % 16) ^ 10);
  endfunction

  // Expected outputs for cycles 0 (start sampled) .. 1+N*P, cut after an abort cycle.
  task automatic build(input int f, input int l, input int gap, input int ab);
    int n, p, k, off, a;
    exp_t e;
    tmp.delete();
    n = (((l - f) % DEPTH) + DEPTH) % DEPTH + 1;
    p = 1 + ON + gap;
    e = '0;
    tmp.push_back(e);
    for (int c = 1; c <= n * p; c++) begin
      k      = (c - 1) / p;
      off    = (c - 1) % p;
      a      = (f + k) % DEPTH;
      e.addr = 6'(a);
      e.busy = 1'b1;
      e.done = 1'b0;
      e.leds = (off >= 1 && off <= ON) ? pat(a) : 4'h0;
      tmp.push_back(e);
    end
    e.addr = 6'(l);
    e.busy = 1'b1;
    e.done = 1'b1;
    e.leds = 4'h0;
    tmp.push_back(e);
    if (ab >= 0)
      while (tmp.size() > ab + 1) void'(tmp.pop_back());
  endtask

  // One playback: start at cycle 0, optional abort cycle, two start pulses while busy.
  task automatic run(input int f, input int l, input int ab, input int s1, input int s2);
    int len_a, len_b, len_max, len_min;
    @(posedge clk); #1;
    first_addr = 6'(f);
    last_addr  = 6'(l);
    start      = 1'b1;
    abort      = (ab == 0);
    build(f, l, 2, ab);
    foreach (tmp[i]) qa.push_back(tmp[i]);
    len_a = tmp.size();
    build(f, l, 0, ab);
    foreach (tmp[i]) qb.push_back(tmp[i]);
    len_b   = tmp.size();
    len_max = (len_a > len_b) ? len_a : len_b;
    len_min = (len_a < len_b) ? len_a : len_b;
    for (int c = 1; c < len_max; c++) begin
      @(posedge clk); #1;
      start      = (c < len_min) && (c == s1 || c == s2);
      abort      = (c == ab);
      first_addr = 6'($urandom);
      last_addr  = 6'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  always @(negedge clk) if (mon_en) begin
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      chk("a_leds", leds_a, ea.leds);
      chk("a_busy", busy_a, ea.busy);
      chk("a_done", done_a, ea.done);
      if (ea.busy) chk("a_rd_addr", rd_addr_a, ea.addr);
    end else begin
      chk("a_idle_leds", leds_a, 0);
      chk("a_idle_busy", busy_a, 0);
      chk("a_idle_done", done_a, 0);
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      chk("b_leds", leds_b, eb.leds);
      chk("b_busy", busy_b, eb.busy);
      chk("b_done", done_b, eb.done);
      if (eb.busy) chk("b_rd_addr", rd_addr_b, eb.addr);
    end else begin
      chk("b_idle_leds", leds_b, 0);
      chk("b_idle_busy", busy_b, 0);
      chk("b_idle_done", done_b, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, l, ab, s1, s2;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr_a", rd_addr_a, 0);
    chk("rst_leds_a", leds_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_leds_b", leds_b, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    run(3, 3, -1, -1, -1);
    run(5, 7, -1, -1, -1);
    run(62, 1, -1, -1, -1);
    run(5, 7, 10, -1, -1);
    run(5, 7, -1, 3, 8);
    run(20, 22, 0, -1, -1);
    run(0, 1, -1, -1, -1);
    run(10, 9, -1, 100, 300);
    run(40, 42, 22, 2, 21);

    for (int i = 0; i < 25; i++) begin
      f  = int'($urandom % DEPTH);
      l  = (f + int'($urandom_range(0, 5))) % DEPTH;
      ab = ($urandom % 4 == 0) ? int'($urandom_range(0, 30)) : -1;
      s1 = int'($urandom_range(1, 12));
      s2 = int'($urandom_range(1, 30));
      run(f, l, ab, s1, s2);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
    end

    // Asynchronous reset in the middle of a playback.
    @(posedge clk); #1;
    mon_en     = 1'b0;
    first_addr = 6'd2;
    last_addr  = 6'd4;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_busy_a", busy_a, 1);
    rst = 1'b0;
    #1;
    chk("midrst_rd_addr_a", rd_addr_a, 0);
    chk("midrst_leds_a", leds_a, 0);
    chk("midrst_busy_a", busy_a, 0);
    chk("midrst_done_a", done_a, 0);
    chk("midrst_rd_addr_b", rd_addr_b, 0);
    chk("midrst_leds_b", leds_b, 0);
    chk("midrst_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (30) @(posedge clk);
    run(60, 61, -1, 4, -1);

    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
